// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - state_t      : scanner states (SCAN, DEBOUNCE, HELD, RELEASE)
//   - KEY_ENTER    : keyCode for '#'
//   - KEY_CLEAR    : keyCode for '*'
//   - KEY_NONE     : keyCode for no key, and for keys A-D
//   - REPEAT_DLY   : sample periods before the first auto-repeat
//   - REPEAT_RATE  : sample periods between later auto-repeats
//   - key_map()    : {row,col} -> keyCode lookup
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [4:0] KEY_ENTER = 5'b00100;
    localparam logic [4:0] KEY_CLEAR = 5'b01100;
    localparam logic [4:0] KEY_NONE  = 5'b00000;

    localparam int REPEAT_DLY  = 16;
    localparam int REPEAT_RATE = 4;

    // Layout (row r, column c):
    //   r0: 1 2 3 A
    //   r1: 4 5 6 B
    //   r2: 7 8 9 C
    //   r3: * 0 # D
    // Digits encode as {1, value}; A-D map to KEY_NONE so they never report.
    function automatic logic [4:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [4:0] code;
        code = KEY_NONE;
        case ({r, c})
            4'h0:    code = 5'b10001;   // 1
            4'h1:    code = 5'b10010;   // 2
            4'h2:    code = 5'b10011;   // 3
            4'h4:    code = 5'b10100;   // 4
            4'h5:    code = 5'b10101;   // 5
            4'h6:    code = 5'b10110;   // 6
            4'h8:    code = 5'b10111;   // 7
            4'h9:    code = 5'b11000;   // 8
            4'hA:    code = 5'b11001;   // 9
            4'hC:    code = KEY_CLEAR;  // *
            4'hD:    code = 5'b10000;   // 0
            4'hE:    code = KEY_ENTER;  // #
            default: code = KEY_NONE;   // A, B, C, D
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Counts consecutive qualifying samples and pulses o_done on the sample that
// completes a run of COUNT. A non-qualifying sample or i_restart clears the run.
//   clock      : rising-edge clock
//   reset      : synchronous, active-high
//   i_strobe   : one-cycle sample strobe
//   i_level    : 1 when the current sample qualifies
//   i_restart  : clears the run (used while the other phase owns the key)
//   o_done     : combinational pulse on the completing sample
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module key_debounce #(
    parameter int COUNT = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic i_strobe,
    input  logic i_level,
    input  logic i_restart,
    output logic o_done
);

    localparam int CNT_W = $clog2(COUNT + 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_done = i_strobe && i_level && (r_cnt == CNT_W'(COUNT - 1));

    always_ff @(posedge clock) begin
        if (reset || i_restart) begin
            r_cnt <= '0;
        end else if (i_strobe) begin
            // A finished run starts over so the next phase counts from zero.
            if (!i_level || o_done) r_cnt <= '0;
            else                    r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// 4x4 matrix keypad scanner with press/release debounce.
//   clock   : rising-edge clock
//   reset   : synchronous, active-high
//   row     : keypad rows, active-low, asynchronous
//   col     : column drive, active-low, one-hot-low
//   newKey  : one-cycle pulse per accepted key (digits, '#', '*')
//   keyCode : {isDigit, value}; valid with newKey and while the key is held
// Parameters: SCAN_DIV (cycles per column, >= 2), DEBOUNCE_CNT (>= 1).
// Optional macro KEYPAD_REPEAT_EN enables auto-repeat of held digit keys.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 8,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       newKey,
    output logic [4:0] keyCode
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_sync;
    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_col_idx;
    logic [1:0]       r_cand_row;
    logic             r_new_key;
    logic [4:0]       r_key_code;
    state_t           r_state;

    state_t     w_state_next;
    logic       w_sample;
    logic       w_any_low;
    logic [1:0] w_low_row;
    logic       w_match;
    logic       w_cand_low;
    logic       w_press_phase;
    logic       w_press_done;
    logic       w_release_done;
    logic       w_advance;
    logic       w_latch;
    logic       w_accept;
    logic       w_clear_code;
    logic       w_repeat;
    logic [4:0] w_code;

    // Rows are sampled on the last cycle of each column period.
    assign w_sample  = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
    assign w_any_low = ~&r_row_sync;

    // Lowest-indexed low row wins.
    always_comb begin
        w_low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_row_sync[i]) w_low_row = 2'(i);
        end
    end

    assign w_match       = w_any_low && (w_low_row == r_cand_row);
    assign w_cand_low    = ~r_row_sync[r_cand_row];
    assign w_press_phase = (r_state == SCAN) || (r_state == DEBOUNCE);

    // The column index is frozen from detection onward, so it is the candidate
    // column; in SCAN the candidate row is not latched yet.
    assign w_code = key_map((r_state == SCAN) ? w_low_row : r_cand_row, r_col_idx);

    key_debounce #(.COUNT(DEBOUNCE_CNT)) u_press_db (
        .clock     (clock),
        .reset     (reset),
        .i_strobe  (w_sample && w_press_phase),
        .i_level   ((r_state == SCAN) ? w_any_low : w_match),
        .i_restart (!w_press_phase),
        .o_done    (w_press_done)
    );

    key_debounce #(.COUNT(DEBOUNCE_CNT)) u_release_db (
        .clock     (clock),
        .reset     (reset),
        .i_strobe  (w_sample && !w_press_phase),
        .i_level   (!w_cand_low),
        .i_restart (w_press_phase),
        .o_done    (w_release_done)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= SCAN;
        else       r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_advance    = 1'b0;
        w_latch      = 1'b0;
        w_accept     = 1'b0;
        w_clear_code = 1'b0;
        case (r_state)
            SCAN: begin
                if (w_sample) begin
                    if (w_any_low) begin
                        w_latch      = 1'b1;
                        w_accept     = w_press_done;
                        w_state_next = w_press_done ? HELD : DEBOUNCE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (w_sample) begin
                    if (!w_match) begin
                        w_advance    = 1'b1;
                        w_state_next = SCAN;
                    end else if (w_press_done) begin
                        w_accept     = 1'b1;
                        w_state_next = HELD;
                    end
                end
            end
            HELD: begin
                if (w_sample && !w_cand_low) begin
                    if (w_release_done) begin
                        w_advance    = 1'b1;
                        w_clear_code = 1'b1;
                        w_state_next = SCAN;
                    end else begin
                        w_state_next = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (w_sample) begin
                    if (w_cand_low) begin
                        w_state_next = HELD;
                    end else if (w_release_done) begin
                        w_advance    = 1'b1;
                        w_clear_code = 1'b1;
                        w_state_next = SCAN;
                    end
                end
            end
            default: w_state_next = SCAN;
        endcase
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DLY);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_armed;
    logic             w_rep_tick;

    // Only digits repeat; counting runs on samples where the key is still down.
    assign w_rep_tick = (r_state == HELD) && w_sample && w_cand_low && r_key_code[4];
    assign w_repeat   = w_rep_tick &&
                        (r_rep_cnt == (r_rep_armed ? REP_W'(REPEAT_RATE - 1)
                                                   : REP_W'(REPEAT_DLY - 1)));

    always_ff @(posedge clock) begin
        if (reset || w_accept) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_tick) begin
            if (w_repeat) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + REP_W'(1);
            end
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clock) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge value of every other flop, independent of block order.
        if (reset) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
            r_div_cnt  <= '0;
            r_col_idx  <= 2'd0;
            r_cand_row <= 2'd0;
            r_new_key  <= 1'b0;
            r_key_code <= KEY_NONE;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
            r_div_cnt  <= w_sample ? '0 : r_div_cnt + DIV_W'(1);
            if (w_advance) r_col_idx  <= r_col_idx + 2'd1;
            if (w_latch)   r_cand_row <= w_low_row;
            r_new_key <= (w_accept && (w_code != KEY_NONE)) || w_repeat;
            if (w_accept)          r_key_code <= w_code;
            else if (w_clear_code) r_key_code <= KEY_NONE;
        end
    end

    assign col     = ~(4'b0001 << r_col_idx);
    assign newKey  = r_new_key;
    assign keyCode = r_key_code;

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
// Self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_CNT=2). A keypad
// matrix model turns pressed keys plus the driven column into row levels; a
// sample-level reference model predicts col/newKey/keyCode every cycle.
// Define KEYPAD_REPEAT_EN for both bench and RTL to cover auto-repeat.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DCNT     = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic       newKey;
    logic [4:0] keyCode;

    logic [3:0] pressed [4] = '{4'h0, 4'h0, 4'h0, 4'h0};  // pressed[r][c]
    logic       glitch0 = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    int         pulse_cnt = 0;
    int         pulse_cyc [$];
    logic [4:0] pulse_code [$];

    always #5 clock = ~clock;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DCNT)) dut (
        .clock   (clock),
        .reset   (reset),
        .row     (row),
        .col     (col),
        .newKey  (newKey),
        .keyCode (keyCode)
    );

    // Matrix: a row reads low when any pressed key on it sits on the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r] & ~col);
        if (glitch0) row[0] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    endtask

    // ---------------- reference model ----------------
    localparam int M_LOOK = 0, M_CONFIRM = 1, M_DOWN = 2, M_UP = 3;

    logic       model_valid = 1'b0;
    logic [3:0] m_hist [$];
    int         m_phase, m_col, m_mode, m_cand_r, m_cand_c, m_cnt, m_held, m_next_rep;
    logic       m_pulse;
    logic [4:0] m_code;

    function automatic logic [4:0] key_code_of(input int r, input int c);
        string labels;
        byte   ch;
        labels = "123A456B789C*0#D";
        ch = labels[r*4 + c];
        if (ch >= "0" && ch <= "9") return {1'b1, 4'(ch - "0")};
        if (ch == "#") return 5'b00100;
        if (ch == "*") return 5'b01100;
        return 5'b00000;
    endfunction

    function automatic int lowest_low(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] v;
        v = 4'hF;
        v[c] = 1'b0;
        return v;
    endfunction

    task automatic accept_key();
        m_code     = key_code_of(m_cand_r, m_cand_c);
        m_pulse    = (m_code != 5'b00000);
        m_mode     = M_DOWN;
        m_held     = 0;
        m_next_rep = 16;
    endtask

    task automatic release_done();
        m_mode = M_LOOK;
        m_col  = (m_col + 1) % 4;
        m_code = 5'b00000;
    endtask

    task automatic take_sample(input logic [3:0] v);
        int lo;
        lo = lowest_low(v);
        case (m_mode)
            M_LOOK: begin
                if (lo >= 0) begin
                    m_cand_r = lo;
                    m_cand_c = m_col;
                    m_cnt    = 1;
                    m_mode   = M_CONFIRM;
                    if (m_cnt == DCNT) accept_key();
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end
            M_CONFIRM: begin
                if (lo == m_cand_r) begin
                    m_cnt++;
                    if (m_cnt == DCNT) accept_key();
                end else begin
                    m_mode = M_LOOK;
                    m_col  = (m_col + 1) % 4;
                end
            end
            M_DOWN: begin
                if (v[m_cand_r]) begin
                    m_cnt  = 1;
                    m_mode = M_UP;
                    if (m_cnt == DCNT) release_done();
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (m_code[4]) begin
                        m_held++;
                        if (m_held == m_next_rep) begin
                            m_pulse    = 1'b1;
                            m_next_rep = m_next_rep + 4;
                        end
                    end
`endif
                end
            end
            default: begin
                if (v[m_cand_r]) begin
                    m_cnt++;
                    if (m_cnt == DCNT) release_done();
                end else begin
                    m_mode = M_DOWN;
                end
            end
        endcase
    endtask

    task automatic model_step(input logic rst, input logic [3:0] row_now);
        logic [3:0] v;
        if (rst) begin
            model_valid = 1'b1;
            m_hist      = '{4'hF, 4'hF};
            m_phase     = 0;
            m_col       = 0;
            m_mode      = M_LOOK;
            m_cnt       = 0;
            m_pulse     = 1'b0;
            m_code      = 5'b00000;
            return;
        end
        if (!model_valid) return;
        v = m_hist.pop_front();   // value seen two edges ago (synchroniser)
        m_hist.push_back(row_now);
        m_pulse = 1'b0;
        if (m_phase == SCAN_DIV - 1) take_sample(v);
        m_phase = (m_phase + 1) % SCAN_DIV;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            cycle++;
            model_step(reset, row);
        end
    end

    // Compare process plus pulse recorder, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (model_valid) begin
                check("col", col, col_drive(m_col));
                check("newKey", newKey, m_pulse);
                check("keyCode", keyCode, m_code);
            end
            if (newKey === 1'b1) begin
                pulse_cnt++;
                pulse_cyc.push_back(cycle);
                pulse_code.push_back(keyCode);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int k);
        pressed[k / 4][k % 4] = 1'b1;
    endtask

    task automatic unpress(input int k);
        pressed[k / 4][k % 4] = 1'b0;
    endtask

    task automatic wait_col(input logic [3:0] target, input string tag);
        int t;
        t = 0;
        while (col !== target && t < 64) begin
            @(negedge clock);
            t++;
        end
        check(tag, col, target);
    endtask

    task automatic align_col0();
        wait_col(4'b0111, "align_col3");
        wait_col(4'b1110, "align_col0");
    endtask

    function automatic logic [4:0] code_at(input int idx);
        if (idx < pulse_code.size()) return pulse_code[idx];
        return 5'h1F;
    endfunction

    task automatic run_random();
        int  k, k2, hold;
        bit  two;
        for (int it = 0; it < 40; it++) begin
            k    = $urandom_range(0, 15);
            k2   = $urandom_range(0, 15);
            two  = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(3, 50);
            press(k);
            if (two) press(k2);
            idle(hold);
            if ($urandom_range(0, 2) == 0) begin
                unpress(k);
                idle($urandom_range(1, 6));
                press(k);
                idle($urandom_range(3, 30));
            end
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
                idle($urandom_range(1, 20));
            end
            unpress(k);
            unpress(k2);
            idle($urandom_range(2, 40));
        end
    endtask

    // ---------------- scenarios ----------------
    int p0, q0, n;

    initial begin
        idle(2);
        check("reset_col", col, 4'b1110);
        check("reset_newKey", newKey, 1'b0);
        check("reset_keyCode", keyCode, 5'b00000);
        reset = 1'b0;

        // '5' held 40 cycles: one pulse, then code clears after release.
        p0 = pulse_cnt; q0 = pulse_code.size();
        press(5); idle(40); unpress(5);
        check("k5_pulses", pulse_cnt - p0, 1);
        check("k5_code", code_at(q0), 5'b10101);
        idle(40);
        check("k5_released_code", keyCode, 5'b00000);

        // '#' then '*'.
        p0 = pulse_cnt; q0 = pulse_code.size();
        press(14); idle(40); unpress(14); idle(40);
        press(12); idle(40); unpress(12); idle(40);
        check("enter_clear_pulses", pulse_cnt - p0, 2);
        check("enter_code", code_at(q0), 5'b00100);
        check("clear_code", code_at(q0 + 1), 5'b01100);

        // One-period glitch on row0 while col0 is driven.
        p0 = pulse_cnt;
        align_col0();
        glitch0 = 1'b1; idle(SCAN_DIV); glitch0 = 1'b0;
        n = 0;
        while (col === 4'b1110 && n < 32) begin @(negedge clock); n++; end
        check("glitch_next_col", col, 4'b1101);
        idle(10);
        check("glitch_pulses", pulse_cnt - p0, 0);

        // 'A' alone: debounced and held, never reported.
        p0 = pulse_cnt;
        press(3); idle(40);
        check("A_pulses", pulse_cnt - p0, 0);
        check("A_code", keyCode, 5'b00000);
        unpress(3); idle(40);

        // '1' and '9' together, scan positioned so col0 comes next.
        p0 = pulse_cnt; q0 = pulse_code.size();
        wait_col(4'b0111, "pair_align");
        press(0); press(10); idle(40);
        check("pair_pulses", pulse_cnt - p0, 1);
        check("pair_code", code_at(q0), 5'b10001);
        unpress(0); idle(40);
        check("nine_pulses", pulse_cnt - p0, 2);
        check("nine_code", code_at(q0 + 1), 5'b11001);
        unpress(10); idle(40);

        // Reset during DEBOUNCE of '7'.
        p0 = pulse_cnt; q0 = pulse_code.size();
        align_col0();
        press(8); idle(SCAN_DIV);
        reset = 1'b1; idle(1);
        check("rst_col", col, 4'b1110);
        check("rst_newKey", newKey, 1'b0);
        reset = 1'b0;
        idle(60);
        check("k7_pulses", pulse_cnt - p0, 1);
        check("k7_code", code_at(q0), 5'b10111);
        unpress(8); idle(40);

        run_random();
        idle(40);

`ifdef KEYPAD_REPEAT_EN
        // Held '3' repeats: first gap 16 periods, then every 4.
        p0 = pulse_cnt; q0 = pulse_code.size();
        press(2); idle(120 * SCAN_DIV); unpress(2); idle(40);
        n = pulse_cnt - p0;
        check("rep_enough_pulses", (n >= 20), 1'b1);
        for (int i = 0; i < n; i++) begin
            check("rep_code", pulse_code[q0 + i], 5'b10011);
            if (i > 0)
                check("rep_gap", pulse_cyc[q0 + i] - pulse_cyc[q0 + i - 1],
                      (i == 1) ? 16 * SCAN_DIV : 4 * SCAN_DIV);
        end
        p0 = pulse_cnt;
        press(14); idle(120 * SCAN_DIV); unpress(14); idle(40);
        check("rep_enter_pulses", pulse_cnt - p0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
